// File: rtl/iobuf_seq_if.sv
// rtl/iobuf_seq_if.sv - NOC enqueue channel and IobufVec pad-vector interfaces
interface noc_if;
  logic         enq__ENA;
  logic [143:0] enq_v;
  logic         enq__RDY;

  modport master (output enq__ENA, output enq_v, input enq__RDY);
  modport slave  (input enq__ENA, input enq_v, output enq__RDY);
endinterface

interface iobuf_pins_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] I;
  logic             T;
  logic [WIDTH-1:0] O;

  modport master (output I, output T, input O);
  modport slave  (input I, input T, output O);
endinterface

// File: rtl/iobuf_seq.sv
// rtl/iobuf_seq.sv - sequences NOC requests into beat-wise pad-vector writes and turnaround reads
module iobuf_seq #(
  parameter int iovecWidth = 16,
  parameter int turnCycles = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  noc_if.slave         in,
  noc_if.master        out,
  iobuf_pins_if.master pins
);
  localparam int         MAXB  = 128 / iovecWidth;
  localparam logic [7:0] MAXB8 = 8'(MAXB);

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, RESP} state_t;

  state_t                 state;
  logic                   run;
  logic [127:0]           data_r;
  logic [7:0]             nbeat;
  logic [7:0]             cnt;
  logic [3:0]             tcnt;
  logic [iovecWidth-1:0]  pin_i;
  logic                   pin_t;
  logic                   resp_vld;
  logic [143:0]           resp;

  logic                   accept;
  logic                   rd_flag;
  logic [7:0]             req_n;
  logic [127:0]           req_data;
  logic [127:0]           cap_data;
  logic                   unused_len_bits;

  assign req_data        = in.enq_v[143:16];
  assign rd_flag         = in.enq_v[15];
  assign req_n           = (in.enq_v[7:0] > MAXB8) ? MAXB8 : in.enq_v[7:0];
  assign unused_len_bits = ^in.enq_v[14:8];

  // run holds ready low until the first edge after reset release
  assign in.enq__RDY = run && (state == IDLE);
  assign accept      = in.enq__ENA && in.enq__RDY;

  always_comb begin
    cap_data = data_r;
    cap_data[cnt*iovecWidth +: iovecWidth] = pins.O;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      run      <= 1'b0;
      data_r   <= '0;
      nbeat    <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      pin_i    <= '0;
      pin_t    <= 1'b1;
      resp_vld <= 1'b0;
      resp     <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            data_r <= rd_flag ? '0 : req_data;
            nbeat  <= req_n;
            tcnt   <= '0;
            cnt    <= '0;
            if (rd_flag) begin
              if (req_n == 8'd0) begin
                state    <= RESP;
                resp_vld <= 1'b1;
                resp     <= {128'b0, 16'h8000};
              end else begin
                state <= TURN;
              end
            end else if (req_n != 8'd0) begin
              // beat 0 goes out directly from the request so beats stay back-to-back
              state <= WRITE;
              pin_t <= 1'b0;
              pin_i <= req_data[iovecWidth-1:0];
              cnt   <= 8'd1;
            end
          end
        end
        WRITE: begin
          if (cnt == nbeat) begin
            state <= IDLE;
            pin_t <= 1'b1;
            pin_i <= '0;
            cnt   <= '0;
          end else begin
            pin_i <= data_r[cnt*iovecWidth +: iovecWidth];
            cnt   <= cnt + 8'd1;
          end
        end
        TURN: begin
          if (tcnt == 4'(turnCycles - 1)) begin
            state <= READ;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        READ: begin
          data_r <= cap_data;
          cnt    <= cnt + 8'd1;
          if (cnt == nbeat - 8'd1) begin
            state    <= RESP;
            resp_vld <= 1'b1;
            resp     <= {cap_data, 8'h80, nbeat};
          end
        end
        RESP: begin
          if (out.enq__RDY) begin
            state    <= IDLE;
            resp_vld <= 1'b0;
            resp     <= '0;
            cnt      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out.enq__ENA = resp_vld;
  assign out.enq_v    = resp;
  assign pins.I       = pin_i;
  assign pins.T       = pin_t;
endmodule
